// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Provides segment/anode idle codes, the hex segment table and the digit index type.
package seg_pkg;

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [3:0] ANODE_OFF = 4'hF;

   // Active-low codes, bit 7 (DP) held high; entry n is hex digit n.
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6,
      8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99,
      8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef logic [1:0] dig_idx_t;

   function automatic logic [3:0] anode_of(dig_idx_t k);
      return ~(4'b0001 << k);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame write channel: 32-bit hex frame, blank and DP masks, valid/ready.
// master drives the frame, slave (the controller) returns wr_ready.
interface seg_scan_ctrl_if;

   logic [31:0] wr_data;
   logic [7:0]  wr_blank;
   logic [7:0]  wr_dp;
   logic        wr_valid;
   logic        wr_ready;

   modport master (
      output wr_data, wr_blank, wr_dp, wr_valid,
      input  wr_ready
   );

   modport slave (
      input  wr_data, wr_blank, wr_dp, wr_valid,
      output wr_ready
   );

endinterface

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code (g..a in bits 6..0).
// Ports: i_nib nibble in, o_seg 7-bit segment code out.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   logic [7:0] w_code;

   assign w_code = HEX_SEG[i_nib];
   assign o_seg  = w_code[6:0];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-display, 4-digit time-multiplexed seven-segment scan controller.
// Ports: clk, rst_n (async, active-low); wr (frame handshake, slave);
//   D0_seg/D1_seg active-low segments (bit 7 = DP); D0_a/D1_a active-low
//   anodes; frame_done one-cycle pulse per scan wrap.
// Option SEG_SCAN_BRIGHTNESS_PWM_EN adds input brightness[3:0] that
//   shortens each digit's on-time to (brightness+1)/16 of the dwell.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int CLK_HZ   = 100_000_000,
   parameter int DIGIT_HZ = 1000
)(
   input  logic       clk,
   input  logic       rst_n,
   seg_scan_ctrl_if.slave wr,
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
   input  logic [3:0] brightness,
`endif
   output logic [7:0] D0_seg,
   output logic [3:0] D0_a,
   output logic [7:0] D1_seg,
   output logic [3:0] D1_a,
   output logic       frame_done
);

   localparam int TICKS = CLK_HZ / DIGIT_HZ;
   localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICKS - 1);

   logic [PW-1:0] r_presc;
   dig_idx_t      r_idx;

   logic [31:0] r_act_data;
   logic [7:0]  r_act_blank;
   logic [7:0]  r_act_dp;
   logic [31:0] r_pnd_data;
   logic [7:0]  r_pnd_blank;
   logic [7:0]  r_pnd_dp;
   logic        r_pnd_v;

   logic        w_tick;
   logic        w_wrap;
   logic        w_xfer;
   logic        w_on;
   logic [3:0]  w_nib0;
   logic [3:0]  w_nib1;
   logic [6:0]  w_code0;
   logic [6:0]  w_code1;
   logic        w_bl0;
   logic        w_bl1;
   logic        w_dp0;
   logic        w_dp1;
   logic        w_off0;
   logic        w_off1;

   assign w_tick = (r_presc == P_LAST);
   assign w_wrap = w_tick && (r_idx == 2'd3);
   assign w_xfer = wr.wr_valid && !r_pnd_v;

   assign wr.wr_ready = ~r_pnd_v;

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
   localparam int STEP = TICKS / 16;
   localparam int LW   = PW + 1;

   logic [3:0]  r_bright;
   logic [3:0]  w_bright;
   logic [LW-1:0] w_lim;

   // Level is taken at the start of each dwell so one digit never
   // shows two different on-times.
   assign w_bright = (r_presc == '0) ? brightness : r_bright;
   assign w_lim    = LW'((32'(w_bright) + 32'd1) * 32'(STEP));
   assign w_on     = ({1'b0, r_presc} < w_lim);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bright <= 4'hF;
      end else if (r_presc == '0) begin
         r_bright <= brightness;
      end
   end
`else
   assign w_on = 1'b1;
`endif

   // D1 uses the same digit index, offset by four nibbles.
   assign w_nib0 = r_act_data[{r_idx, 2'b00} +: 4];
   assign w_nib1 = r_act_data[{1'b1, r_idx, 2'b00} +: 4];
   assign w_bl0  = r_act_blank[{1'b0, r_idx}];
   assign w_bl1  = r_act_blank[{1'b1, r_idx}];
   assign w_dp0  = r_act_dp[{1'b0, r_idx}];
   assign w_dp1  = r_act_dp[{1'b1, r_idx}];
   assign w_off0 = w_bl0 || !w_on;
   assign w_off1 = w_bl1 || !w_on;

   seg_hex_decode u_dec0 (
      .i_nib (w_nib0),
      .o_seg (w_code0)
   );

   seg_hex_decode u_dec1 (
      .i_nib (w_nib1),
      .o_seg (w_code1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc    <= '0;
         r_idx      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_wrap;
         if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // Commit uses the pre-edge pending flag, so a frame accepted on the
   // wrap edge waits for the following wrap. Capture and commit are
   // exclusive because capture requires the pending slot to be empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act_data  <= '0;
         r_act_blank <= 8'hFF;
         r_act_dp    <= '0;
         r_pnd_data  <= '0;
         r_pnd_blank <= '0;
         r_pnd_dp    <= '0;
         r_pnd_v     <= 1'b0;
      end else if (w_wrap && r_pnd_v) begin
         r_act_data  <= r_pnd_data;
         r_act_blank <= r_pnd_blank;
         r_act_dp    <= r_pnd_dp;
         r_pnd_v     <= 1'b0;
      end else if (w_xfer) begin
         r_pnd_data  <= wr.wr_data;
         r_pnd_blank <= wr.wr_blank;
         r_pnd_dp    <= wr.wr_dp;
         r_pnd_v     <= 1'b1;
      end
   end

   // Segments and anodes share one register stage so they switch together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         D0_seg <= SEG_OFF;
         D1_seg <= SEG_OFF;
         D0_a   <= ANODE_OFF;
         D1_a   <= ANODE_OFF;
      end else begin
         D0_seg <= w_off0 ? SEG_OFF : {~w_dp0, w_code0};
         D1_seg <= w_off1 ? SEG_OFF : {~w_dp1, w_code1};
         D0_a   <= w_off0 ? ANODE_OFF : anode_of(r_idx);
         D1_a   <= w_off1 ? ANODE_OFF : anode_of(r_idx);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with TICKS = 16.
// Frame vectors from a table feed a scoreboard checked mid-dwell.
module tb_seg_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic [7:0] D0_seg;
   logic [3:0] D0_a;
   logic [7:0] D1_seg;
   logic [3:0] D1_a;
   logic       frame_done;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
   logic [3:0] brightness;
`endif

   seg_scan_ctrl_if wr_if ();

   seg_scan_ctrl #(
      .CLK_HZ   (1600),
      .DIGIT_HZ (100)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (wr_if),
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
      .brightness (brightness),
`endif
      .D0_seg     (D0_seg),
      .D0_a       (D0_a),
      .D1_seg     (D1_seg),
      .D1_a       (D1_a),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     data;
      logic [7:0]      blank;
      logic [7:0]      dp;
      logic [3:0][7:0] s0;
      logic [3:0][3:0] a0;
      logic [3:0][7:0] s1;
      logic [3:0][3:0] a1;
   } vec_t;

   typedef struct {
      logic [7:0] s0;
      logic [7:0] s1;
      logic [3:0] a0;
      logic [3:0] a1;
   } exp_t;

   vec_t vt[4];
   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic push_vec(vec_t v);
      for (int k = 0; k < 4; k++)
         sbq.push_back('{s0: v.s0[k], s1: v.s1[k], a0: v.a0[k], a1: v.a1[k]});
   endtask

   task automatic offer(vec_t v, output bit skip);
      @(negedge clk);
      wr_if.wr_data  = v.data;
      wr_if.wr_blank = v.blank;
      wr_if.wr_dp    = v.dp;
      wr_if.wr_valid = 1'b1;
      chk("ready_at_offer", 32'(wr_if.wr_ready), 1);
      @(posedge clk);
      #1;
      wr_if.wr_valid = 1'b0;
      skip = frame_done;
   endtask

   task automatic wait_fd(input bit skip);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (frame_done) begin
            if (skip) skip = 0;
            else begin
               ok = 1;
               break;
            end
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL fd_timeout act=none exp=frame_done");
      end
   endtask

   // Called at the frame_done sample; digit k is visible 1+16k..16+16k.
   task automatic cmp_frame(string nm);
      exp_t e;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb_empty act=0 exp=1", nm);
         end else begin
            e = sbq.pop_front();
            chk($sformatf("%s_d%0d_s0", nm, k), 32'(D0_seg), 32'(e.s0));
            chk($sformatf("%s_d%0d_a0", nm, k), 32'(D0_a), 32'(e.a0));
            chk($sformatf("%s_d%0d_s1", nm, k), 32'(D1_seg), 32'(e.s1));
            chk($sformatf("%s_d%0d_a1", nm, k), 32'(D1_a), 32'(e.a1));
         end
         if (k < 3) repeat (16) @(negedge clk);
      end
   endtask

   task automatic chk_idle(string nm);
      chk({nm, "_s0"}, 32'(D0_seg), 32'hFF);
      chk({nm, "_s1"}, 32'(D1_seg), 32'hFF);
      chk({nm, "_a0"}, 32'(D0_a), 32'hF);
      chk({nm, "_a1"}, 32'(D1_a), 32'hF);
      chk({nm, "_rdy"}, 32'(wr_if.wr_ready), 1);
      chk({nm, "_fd"}, 32'(frame_done), 0);
   endtask

   initial begin
      bit skip;
      int n;
      int on_cnt;

      vt[0] = '{32'h7654_3210, 8'h00, 8'h00,
                {8'hB0, 8'hA4, 8'hF9, 8'hC0}, {4'h7, 4'hB, 4'hD, 4'hE},
                {8'hF8, 8'h82, 8'h92, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE}};
      vt[1] = '{32'hFFFF_FFFF, 8'h81, 8'h02,
                {8'h8E, 8'h8E, 8'h0E, 8'hFF}, {4'h7, 4'hB, 4'hD, 4'hF},
                {8'hFF, 8'h8E, 8'h8E, 8'h8E}, {4'hF, 4'hB, 4'hD, 4'hE}};
      vt[2] = '{32'h89AB_CDEF, 8'h00, 8'hF0,
                {8'hC6, 8'hA1, 8'h86, 8'h8E}, {4'h7, 4'hB, 4'hD, 4'hE},
                {8'h00, 8'h10, 8'h08, 8'h03}, {4'h7, 4'hB, 4'hD, 4'hE}};
      vt[3] = '{32'h0000_0000, 8'h24, 8'h01,
                {8'hC0, 8'hFF, 8'hC0, 8'h40}, {4'h7, 4'hF, 4'hD, 4'hE},
                {8'hC0, 8'hC0, 8'hFF, 8'hC0}, {4'h7, 4'hB, 4'hF, 4'hE}};

      rst_n          = 1'b0;
      wr_if.wr_data  = '0;
      wr_if.wr_blank = '0;
      wr_if.wr_dp    = '0;
      wr_if.wr_valid = 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
      brightness = 4'hF;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Active frame after reset is fully blanked.
      wait_fd(0);
      repeat (8) @(negedge clk);
      chk("post_reset_blank_s0", 32'(D0_seg), 32'hFF);
      chk("post_reset_blank_a1", 32'(D1_a), 32'hF);

      for (int i = 0; i < 4; i++) begin
         offer(vt[i], skip);
         push_vec(vt[i]);
         wait_fd(skip);
         cmp_frame($sformatf("vec%0d", i));
      end

      // Second offer while pending is ignored.
      offer(vt[2], skip);
      push_vec(vt[2]);
      wr_if.wr_data  = 32'h0;
      wr_if.wr_blank = 8'h00;
      wr_if.wr_dp    = 8'h00;
      wr_if.wr_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk($sformatf("bp_ready%0d", j), 32'(wr_if.wr_ready), 0);
      end
      wr_if.wr_valid = 1'b0;
      wait_fd(skip);
      chk("ready_after_commit", 32'(wr_if.wr_ready), 1);
      cmp_frame("bp");

      // Transfer during the frame_done cycle commits one frame later.
      wait_fd(0);
      wr_if.wr_data  = vt[1].data;
      wr_if.wr_blank = vt[1].blank;
      wr_if.wr_dp    = vt[1].dp;
      wr_if.wr_valid = 1'b1;
      chk("fdcyc_ready", 32'(wr_if.wr_ready), 1);
      @(posedge clk);
      #1;
      wr_if.wr_valid = 1'b0;
      push_vec(vt[1]);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (frame_done) break;
      end
      chk("fdcyc_gap", 32'(n), 64);
      cmp_frame("fdcyc");

      // Transfer on the wrap edge itself: old frame stays for one scan.
      repeat (7) @(negedge clk);
      wr_if.wr_data  = vt[3].data;
      wr_if.wr_blank = vt[3].blank;
      wr_if.wr_dp    = vt[3].dp;
      wr_if.wr_valid = 1'b1;
      chk("bnd_ready", 32'(wr_if.wr_ready), 1);
      @(posedge clk);
      #1;
      wr_if.wr_valid = 1'b0;
      chk("bnd_fd", 32'(frame_done), 1);
      chk("bnd_ready_low", 32'(wr_if.wr_ready), 0);
      push_vec(vt[3]);
      repeat (9) @(negedge clk);
      chk("bnd_old_s0", 32'(D0_seg), 32'hFF);
      chk("bnd_old_s1", 32'(D1_seg), 32'h8E);
      wait_fd(0);
      cmp_frame("bnd");

      // Period, width and anode on-time over whole frames.
      wait_fd(0);
      for (int r = 0; r < 3; r++) begin
         n = 0;
         on_cnt = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (D0_a != 4'hF) on_cnt++;
            if (i == 0) chk($sformatf("fd_width%0d", r), 32'(frame_done), 0);
            if (frame_done) break;
         end
         chk($sformatf("fd_period%0d", r), 32'(n), 64);
         if (r == 0) chk("anode_on_full", 32'(on_cnt), 48);
      end

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
      brightness = 4'd3;
      wait_fd(0);
      wait_fd(0);
      on_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (D0_a != 4'hF) on_cnt++;
      end
      chk("pwm_b3_on", 32'(on_cnt), 12);
      brightness = 4'hF;
`endif

      // Asynchronous reset mid-scan drops the pending frame.
      offer(vt[0], skip);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      wait_fd(0);
      repeat (8) @(negedge clk);
      chk("rst_drop_s0", 32'(D0_seg), 32'hFF);
      chk("rst_drop_a1", 32'(D1_a), 32'hF);
      chk("rst_drop_rdy", 32'(wr_if.wr_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
